// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction size, alignment check.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_HALT     = 2'd3
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned ALIGN_BITS  = $clog2(INSTR_BYTES);

   // A fetch address is legal only when it sits on an instruction boundary
   function automatic logic is_aligned(input logic [31:0] addr);
      return addr[ALIGN_BITS-1:0] == '0;
   endfunction

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-PC / next-state selector for the fetch unit.
// Priority inside RUN/REDIRECT: halt request, branch, jump, bubble countdown, stall, advance.
module pc_next_select
   import mips_pkg::*;
#(
   parameter int unsigned REDIRECT_BUBBLES = 1
)(
   input  fetch_state_e state_i,
   input  logic [31:0]  pc_i,
   input  logic [31:0]  pc_add_i,
   input  logic         branch_taken_i,
   input  logic [31:0]  branch_target_i,
   input  logic         branch_aligned_i,
   input  logic         jump_taken_i,
   input  logic [31:0]  jump_target_i,
   input  logic         jump_aligned_i,
   input  logic         stall_i,
   input  logic         halt_req_i,
   input  logic         resume_i,
   input  logic         align_err_i,
   input  logic         bubble_done_i,
   output logic [31:0]  pc_next_o,
   output fetch_state_e state_next_o,
   output logic         align_err_next_o,
   output logic         redirect_o,
   output logic         advance_o
);

   logic        take_redirect;
   logic [31:0] redirect_target;
   logic        target_ok;

   // The branch is older than the jump in ID, so it wins when both fire
   assign take_redirect   = branch_taken_i | jump_taken_i;
   assign redirect_target = branch_taken_i ? branch_target_i  : jump_target_i;
   assign target_ok       = branch_taken_i ? branch_aligned_i : jump_aligned_i;

   // Select next PC, next state and error flag from the current state and requests
   always_comb begin
      pc_next_o        = pc_i;
      state_next_o     = state_i;
      align_err_next_o = align_err_i;
      redirect_o       = 1'b0;
      advance_o        = 1'b0;
      case (state_i)
         ST_BOOT: begin
            state_next_o = ST_RUN;
         end
         ST_RUN, ST_REDIRECT: begin
            if (halt_req_i) begin
               state_next_o = ST_HALT;
            end else if (take_redirect) begin
               if (target_ok) begin
                  pc_next_o    = redirect_target;
                  redirect_o   = 1'b1;
                  state_next_o = (REDIRECT_BUBBLES > 0) ? ST_REDIRECT : ST_RUN;
               end else begin
                  align_err_next_o = 1'b1;
                  state_next_o     = ST_HALT;
               end
            end else if (state_i == ST_REDIRECT) begin
               // Stall does not stretch the bubble; the hazard unit flushes ID anyway
               if (bubble_done_i) begin
                  state_next_o = ST_RUN;
               end
            end else if (!stall_i) begin
               pc_next_o = pc_add_i;
               advance_o = 1'b1;
            end
         end
         ST_HALT: begin
            // A misaligned-target trap can only be left through reset
            if (resume_i && !align_err_i) begin
               state_next_o = ST_RUN;
            end
         end
         default: begin
            state_next_o = ST_BOOT;
         end
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: holds PC, bubble counter, fetch counter and trap flag.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
   parameter int unsigned REDIRECT_BUBBLES = 1
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCAddResult,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        JumpTaken,
   input  logic [31:0] JumpTarget,
   input  logic        Stall,
   input  logic        HaltReq,
   input  logic        Resume,
   output logic [31:0] PCResult,
   output logic        FetchValid,
   output logic [31:0] FetchCount,
   output logic        AlignError,
   output logic        Halted
);

   // Counter reload leaves REDIRECT after REDIRECT_BUBBLES invalid cycles
   localparam logic [1:0] BUBBLE_LOAD =
      (REDIRECT_BUBBLES > 0) ? 2'(REDIRECT_BUBBLES - 1) : 2'd0;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [1:0]   bubble_q, bubble_d;
   logic [31:0]  count_q, count_d;
   logic         align_err_q, align_err_d;
   logic         redirect;
   logic         advance;

   pc_next_select #(
      .REDIRECT_BUBBLES (REDIRECT_BUBBLES)
   ) u_sel (
      .state_i          (state_q),
      .pc_i             (pc_q),
      .pc_add_i         (PCAddResult),
      .branch_taken_i   (BranchTaken),
      .branch_target_i  (BranchTarget),
      .branch_aligned_i (is_aligned(BranchTarget)),
      .jump_taken_i     (JumpTaken),
      .jump_target_i    (JumpTarget),
      .jump_aligned_i   (is_aligned(JumpTarget)),
      .stall_i          (Stall),
      .halt_req_i       (HaltReq),
      .resume_i         (Resume),
      .align_err_i      (align_err_q),
      .bubble_done_i    (bubble_q == 2'd0),
      .pc_next_o        (pc_d),
      .state_next_o     (state_d),
      .align_err_next_o (align_err_d),
      .redirect_o       (redirect),
      .advance_o        (advance)
   );

   // Bubble counter reloads on every redirect and counts down while in REDIRECT;
   // the fetch counter only counts sequential advances, wrapping naturally
   always_comb begin
      bubble_d = bubble_q;
      if (redirect) begin
         bubble_d = BUBBLE_LOAD;
      end else if (state_q == ST_REDIRECT && bubble_q != 2'd0) begin
         bubble_d = bubble_q - 2'd1;
      end
      count_d = count_q + {31'd0, advance};
   end

   // All fetch-unit state, reset asynchronously to the boot condition
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_VECTOR;
         bubble_q    <= 2'd0;
         count_q     <= 32'd0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         bubble_q    <= bubble_d;
         count_q     <= count_d;
         align_err_q <= align_err_d;
      end
   end

   assign PCResult   = pc_q;
   assign FetchValid = (state_q == ST_RUN);
   assign Halted     = (state_q == ST_HALT);
   assign FetchCount = count_q;
   assign AlignError = align_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with an attached PC+4 adder and a
// behavioural model tracking PC, fetch count, trap flag and remaining bubbles.
module tb_pc_fetch_unit;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam int          BUB = 1;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] PCAddResult;
   logic        BranchTaken, JumpTaken, Stall, HaltReq, Resume;
   logic [31:0] BranchTarget, JumpTarget;
   logic [31:0] PCResult, FetchCount;
   logic        FetchValid, AlignError, Halted;

   int n_cmp = 0;
   int n_bad = 0;

   // model: mode 0=booting, 1=fetching, 2=halted; m_bub = invalid cycles left
   int          m_mode;
   int          m_bub;
   logic [31:0] m_pc, m_cnt;
   logic        m_err;

   pc_fetch_unit #(.RESET_VECTOR(RV), .REDIRECT_BUBBLES(BUB)) dut (
      .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .JumpTaken(JumpTaken), .JumpTarget(JumpTarget),
      .Stall(Stall), .HaltReq(HaltReq), .Resume(Resume),
      .PCResult(PCResult), .FetchValid(FetchValid), .FetchCount(FetchCount),
      .AlignError(AlignError), .Halted(Halted)
   );

   always #5 Clk = ~Clk;
   assign PCAddResult = PCResult + 32'd4;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: sim time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      BranchTaken = 0; JumpTaken = 0; Stall = 0; HaltReq = 0; Resume = 0;
      BranchTarget = 32'h0; JumpTarget = 32'h0;
   endtask

   task automatic model_reset();
      m_mode = 0; m_bub = 0; m_pc = RV; m_cnt = 0; m_err = 0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         if (Resume && !m_err) m_mode = 1;
      end else begin
         tgt = BranchTaken ? BranchTarget : JumpTarget;
         if (HaltReq) begin
            m_mode = 2; m_bub = 0;
         end else if (BranchTaken || JumpTaken) begin
            if (tgt % 4 != 0) begin
               m_err = 1; m_mode = 2; m_bub = 0;
            end else begin
               m_pc = tgt; m_bub = BUB;
            end
         end else if (m_bub > 0) begin
            m_bub = m_bub - 1;
         end else if (!Stall) begin
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
         end
      end
   endtask

   // advance one clock; model sees the same inputs the DUT samples
   task automatic tick();
      if (Reset) model_step();
      @(posedge Clk);
      #1;
   endtask

   // reset pulse placed between edges; leaves the DUT in BOOT
   task automatic do_reset();
      Reset = 0;
      model_reset();
      #4;
      Reset = 1;
   endtask

   task automatic test_reset();
      Reset = 0;
      clear_inputs();
      model_reset();
      @(posedge Clk);
      #1;
      n_cmp++;
      if ({PCResult, FetchCount, FetchValid, AlignError, Halted} !== {RV, 32'd0, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_state: got pc=%h cnt=%0d v=%b e=%b h=%b want pc=%h cnt=0 v=0 e=0 h=0",
                  PCResult, FetchCount, FetchValid, AlignError, Halted, RV);
      end
      Reset = 1;
      #1;
      n_cmp++;
      if ({PCResult, FetchValid} !== {RV, 1'b0}) begin
         n_bad++;
         $display("FAIL boot_hold: got pc=%h v=%b want pc=%h v=0", PCResult, FetchValid, RV);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({PCResult, FetchValid} !== {exp_pc[i], 1'b1}) begin
            n_bad++;
            $display("FAIL seq_step%0d: got pc=%h v=%b want pc=%h v=1", i, PCResult, FetchValid, exp_pc[i]);
         end
      end
      n_cmp++;
      if (FetchCount !== 32'd3) begin
         n_bad++;
         $display("FAIL seq_count: got %0d want 3", FetchCount);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      tick(); tick(); tick();
      BranchTaken = 1; BranchTarget = 32'h40; JumpTaken = 1; JumpTarget = 32'h80;
      tick();
      clear_inputs();
      n_cmp++;
      if ({PCResult, FetchValid, FetchCount} !== {32'h40, 1'b0, 32'd2}) begin
         n_bad++;
         $display("FAIL redirect_bubble: got pc=%h v=%b cnt=%0d want pc=00000040 v=0 cnt=2",
                  PCResult, FetchValid, FetchCount);
      end
      tick();
      n_cmp++;
      if ({PCResult, FetchValid} !== {32'h40, 1'b1}) begin
         n_bad++;
         $display("FAIL redirect_target: got pc=%h v=%b want pc=00000040 v=1", PCResult, FetchValid);
      end
      tick();
      n_cmp++;
      if ({PCResult, FetchValid, FetchCount} !== {32'h44, 1'b1, 32'd3}) begin
         n_bad++;
         $display("FAIL redirect_next: got pc=%h v=%b cnt=%0d want pc=00000044 v=1 cnt=3",
                  PCResult, FetchValid, FetchCount);
      end
   endtask

   task automatic test_stall();
      logic [31:0] cnt0;
      BranchTaken = 1; BranchTarget = 32'h10;
      tick();
      clear_inputs();
      tick();
      cnt0 = m_cnt;
      Stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({PCResult, FetchCount, FetchValid} !== {32'h10, cnt0, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got pc=%h cnt=%0d v=%b want pc=00000010 cnt=%0d v=1",
                     i, PCResult, FetchCount, FetchValid, cnt0);
         end
      end
      JumpTaken = 1; JumpTarget = 32'h100;
      tick();
      clear_inputs();
      n_cmp++;
      if (PCResult !== 32'h100) begin
         n_bad++;
         $display("FAIL stall_jump: got pc=%h want 00000100", PCResult);
      end
   endtask

   task automatic test_misaligned();
      tick();
      JumpTaken = 1; JumpTarget = 32'h102;
      tick();
      clear_inputs();
      n_cmp++;
      if ({AlignError, Halted, PCResult} !== {2'b11, 32'h100}) begin
         n_bad++;
         $display("FAIL misalign_trap: got e=%b h=%b pc=%h want e=1 h=1 pc=00000100",
                  AlignError, Halted, PCResult);
      end
      Resume = 1;
      tick();
      tick();
      Resume = 0;
      n_cmp++;
      if ({Halted, FetchValid, AlignError} !== 3'b101) begin
         n_bad++;
         $display("FAIL misalign_resume: got h=%b v=%b e=%b want h=1 v=0 e=1", Halted, FetchValid, AlignError);
      end
      Reset = 0;
      model_reset();
      #1;
      n_cmp++;
      if ({AlignError, Halted, PCResult} !== {2'b00, RV}) begin
         n_bad++;
         $display("FAIL misalign_reset: got e=%b h=%b pc=%h want e=0 h=0 pc=%h", AlignError, Halted, PCResult, RV);
      end
      #2;
      Reset = 1;
   endtask

   task automatic test_halt();
      tick();
      BranchTaken = 1; BranchTarget = 32'h20;
      tick();
      clear_inputs();
      tick();
      HaltReq = 1;
      tick();
      HaltReq = 0;
      for (int i = 0; i < 5; i++) begin
         BranchTaken = (i % 2 == 0); BranchTarget = 32'h200;
         tick();
         n_cmp++;
         if ({Halted, FetchValid, PCResult} !== {2'b10, 32'h20}) begin
            n_bad++;
            $display("FAIL halt_hold%0d: got h=%b v=%b pc=%h want h=1 v=0 pc=00000020",
                     i, Halted, FetchValid, PCResult);
         end
      end
      clear_inputs();
      Resume = 1;
      tick();
      Resume = 0;
      n_cmp++;
      if ({Halted, FetchValid, PCResult} !== {2'b01, 32'h20}) begin
         n_bad++;
         $display("FAIL halt_resume: got h=%b v=%b pc=%h want h=0 v=1 pc=00000020", Halted, FetchValid, PCResult);
      end
      tick();
      n_cmp++;
      if (PCResult !== 32'h24) begin
         n_bad++;
         $display("FAIL halt_next: got pc=%h want 00000024", PCResult);
      end
   endtask

   task automatic test_async_reset();
      BranchTaken = 1; BranchTarget = 32'h300;
      tick();
      clear_inputs();
      #3;
      Reset = 0;
      model_reset();
      #1;
      n_cmp++;
      if ({PCResult, FetchCount, FetchValid, AlignError, Halted} !== {RV, 32'd0, 3'b000}) begin
         n_bad++;
         $display("FAIL async_reset: got pc=%h cnt=%0d v=%b e=%b h=%b want pc=%h cnt=0 v=0 e=0 h=0",
                  PCResult, FetchCount, FetchValid, AlignError, Halted, RV);
      end
      Reset = 1;
   endtask

   task automatic test_wrap();
      tick();
      BranchTaken = 1; BranchTarget = 32'hFFFF_FFFC;
      tick();
      clear_inputs();
      tick();
      n_cmp++;
      if ({PCResult, FetchValid} !== {32'hFFFF_FFFC, 1'b1}) begin
         n_bad++;
         $display("FAIL wrap_preload: got pc=%h v=%b want pc=fffffffc v=1", PCResult, FetchValid);
      end
      tick();
      n_cmp++;
      if ({PCResult, AlignError, FetchValid, FetchCount} !== {32'h0, 2'b01, 32'd1}) begin
         n_bad++;
         $display("FAIL wrap_next: got pc=%h e=%b v=%b cnt=%0d want pc=00000000 e=0 v=1 cnt=1",
                  PCResult, AlignError, FetchValid, FetchCount);
      end
   endtask

   task automatic test_random();
      logic [31:0] t;
      logic        exp_v, exp_h;
      for (int i = 0; i < 400; i++) begin
         if (m_err && $urandom_range(0, 7) == 0) begin
            do_reset();
         end
         t = $urandom & ~32'h3;
         if ($urandom_range(0, 15) == 0) t = t | 32'($urandom_range(1, 3));
         BranchTarget = t;
         t = $urandom & 32'h0000_FFFC;
         if ($urandom_range(0, 15) == 0) t = t | 32'($urandom_range(1, 3));
         JumpTarget  = t;
         BranchTaken = ($urandom_range(0, 9) == 0);
         JumpTaken   = ($urandom_range(0, 9) == 0);
         HaltReq     = ($urandom_range(0, 19) == 0);
         Resume      = ($urandom_range(0, 2) == 0);
         Stall       = ($urandom_range(0, 3) == 0);
         tick();
         exp_v = (m_mode == 1) && (m_bub == 0);
         exp_h = (m_mode == 2);
         n_cmp++;
         if ({PCResult, FetchCount, FetchValid, Halted, AlignError} !== {m_pc, m_cnt, exp_v, exp_h, m_err}) begin
            n_bad++;
            $display("FAIL random%0d: got pc=%h cnt=%0d v=%b h=%b e=%b want pc=%h cnt=%0d v=%b h=%b e=%b",
                     i, PCResult, FetchCount, FetchValid, Halted, AlignError,
                     m_pc, m_cnt, exp_v, exp_h, m_err);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirect();
      test_stall();
      test_misaligned();
      test_halt();
      test_async_reset();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
